register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
//   Parametrised multi-port CPU register file, successor to the 8x32 single-write file.
//   Two async read ports, two write ports with fixed priority, optional write-to-read bypass,
//   optional hardwired-zero register 0, per-register busy scoreboard for hazard detection.
//   Sits in the decode/writeback stages; flattened debug buses feed the board display logic.
// PARAMETERS
//   DATA_W   32  register width in bits
//   ADDR_W   3   address width; DEPTH = 2**ADDR_W registers, so no out-of-range address exists
//   BYPASS   1   1: same-cycle write data is forwarded to read ports; 0: reads see stored value only
//   ZERO_REG 0   1: register 0 always reads 0, ignores writes, never becomes busy
// PORTS
//   clk       in   1               clock, all state updates on rising edge
//   rst       in   1               synchronous reset, active-high
//   ra1, ra2  in   ADDR_W          read addresses
//   rd1, rd2  out  DATA_W          read data (combinational)
//   rbusy1/2  out  1               busy flag of ra1/ra2 (combinational)
//   we_a      in   1               write enable, port A
//   wa_a      in   ADDR_W          write address, port A
//   wd_a      in   DATA_W          write data, port A
//   we_b, wa_b, wd_b  in  1/ADDR_W/DATA_W   write port B (priority over A)
//   set_en    in   1               mark register set_addr busy (destination issued)
//   set_addr  in   ADDR_W          register to mark busy
//   dbg_addr  in   ADDR_W          debug read address
//   dbg_data  out  DATA_W          registered debug read, 1-cycle latency
//   r_all     out  DATA_W*DEPTH    all stored registers, reg i at [i*DATA_W +: DATA_W]
//   busy_all  out  DEPTH           busy bit i = register i pending
// BEHAVIOUR
//   Reset: rst=1 at an edge clears every register, every busy bit and dbg_data to 0;
//     writes and sets presented in that cycle are discarded. rd1/rd2/rbusy reflect cleared
//     state combinationally from the following cycle (bypass still active while rst=1 is NOT
//     allowed: with rst=1 bypass is suppressed and rd = stored value).
//   Write: at edge, we_a stores wd_a at wa_a; we_b stores wd_b at wa_b.
//     wa_a == wa_b with both enabled -> wd_b stored; wd_a dropped.
//   Read: rd = stored[ra]. BYPASS=1 and not rst: if we_b && wa_b==ra -> wd_b;
//     else if we_a && wa_a==ra -> wd_a; else stored value. Both ports evaluated independently.
//   Zero: ZERO_REG=1 -> writes to addr 0 ignored, rd=0 and rbusy=0 for addr 0 regardless of
//     bypass, busy_all[0]=0, r_all slot 0 = 0.
//   Scoreboard (per register): next busy = set_en&&set_addr==i ? 1 :
//     (write on A or B to i) ? 0 : busy. Set and write to same register in one cycle -> busy=1
//     (new producer issued). Write to a non-busy register is legal, busy stays 0.
//   rbusy: busy[ra]; BYPASS=1 -> 0 when a write to ra is enabled this cycle (data forwarded).
//     set_en does not affect rbusy combinationally (takes effect next cycle).
//   Debug: dbg_data <= stored[dbg_addr] each edge (pre-write value of the same edge).
//   r_all / busy_all show stored state only, never bypassed.
//   Latency: write visible in stored state 1 cycle after enable; bypassed reads 0 cycles.
// TESTING
//   1 rst=1 one edge after random writes -> r_all==0, busy_all==0, dbg_data==0, rd1=rd2=0.
//   2 we_a=1 wa_a=3 wd_a=32'hAAAAAAAA, ra1=3 same cycle -> rd1=AAAAAAAA (BYPASS=1),
//     stored value 0 with BYPASS=0; next cycle rd1=AAAAAAAA in both builds.
//   3 we_a=1 wa_a=5 wd_a=32'h12345678 and we_b=1 wa_b=5 wd_b=32'h87654321 -> reg5=87654321,
//     same-cycle ra2=5 reads 87654321.
//   4 set_en set_addr=6 -> next cycle busy_all[6]=1, rbusy1=1 for ra1=6; then we_b wa_b=6
//     wd_b=32'h11111111 -> rbusy1=0 same cycle (BYPASS=1), busy_all[6]=0 after edge.
//   5 set_en set_addr=2 with we_a wa_a=2 same edge -> busy_all[2]=1, reg2 updated.
//   6 ZERO_REG=1: we_a wa_a=0 wd_a=32'hFFFFFFFF, set_en set_addr=0 -> rd1(ra1=0)=0,
//     busy_all[0]=0, dbg_addr=0 gives dbg_data=0 one cycle later.

Source files
------------

// File: rtl/register_file_mp_if.sv
// Port bundle for register_file_mp: read ports, two write ports, scoreboard set port
// and the flattened debug views. The register file uses the slave side.
interface register_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [ADDR_W-1:0]       ra1;
  logic [ADDR_W-1:0]       ra2;
  logic [DATA_W-1:0]       rd1;
  logic [DATA_W-1:0]       rd2;
  logic                    rbusy1;
  logic                    rbusy2;
  logic                    we_a;
  logic [ADDR_W-1:0]       wa_a;
  logic [DATA_W-1:0]       wd_a;
  logic                    we_b;
  logic [ADDR_W-1:0]       wa_b;
  logic [DATA_W-1:0]       wd_b;
  logic                    set_en;
  logic [ADDR_W-1:0]       set_addr;
  logic [ADDR_W-1:0]       dbg_addr;
  logic [DATA_W-1:0]       dbg_data;
  logic [DATA_W*DEPTH-1:0] r_all;
  logic [DEPTH-1:0]        busy_all;

  modport master (
    output ra1, ra2, we_a, wa_a, wd_a, we_b, wa_b, wd_b, set_en, set_addr, dbg_addr,
    input  rd1, rd2, rbusy1, rbusy2, dbg_data, r_all, busy_all
  );

  modport slave (
    input  ra1, ra2, we_a, wa_a, wd_a, we_b, wa_b, wd_b, set_en, set_addr, dbg_addr,
    output rd1, rd2, rbusy1, rbusy2, dbg_data, r_all, busy_all
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port CPU register file: two combinational read ports, two write ports (B wins
// over A on the same address), optional same-cycle write forwarding, optional hardwired
// zero register, and a per-register busy scoreboard for hazard detection.
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  register_file_mp_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  wr_hit;
  logic [DATA_W-1:0] dbg_q;

  // Port write enables after removing writes to the hardwired zero register.
  logic wr_a_ok;
  logic wr_b_ok;
  assign wr_a_ok = bus.we_a && !(ZERO_REG && bus.wa_a == '0);
  assign wr_b_ok = bus.we_b && !(ZERO_REG && bus.wa_b == '0);

  // Decode which registers receive a write this cycle (retires a pending producer).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_hit[i] = (wr_a_ok && bus.wa_a == ADDR_W'(i)) || (wr_b_ok && bus.wa_b == ADDR_W'(i));
    end
  end

  // Storage, scoreboard and debug register; port B is written last so it wins on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register array is explicitly cleared on reset because software relies on all registers reading 0 afterwards.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy  <= '0;
      dbg_q <= '0;
    end else begin
      // NOTE: non-blocking assignments; with two writes to one address the later statement (port B) takes effect.
      if (wr_a_ok) mem[bus.wa_a] <= bus.wd_a;
      if (wr_b_ok) mem[bus.wa_b] <= bus.wd_b;
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.set_en && bus.set_addr == ADDR_W'(i) && !(ZERO_REG && i == 0)) begin
          busy[i] <= 1'b1;
        end else if (wr_hit[i]) begin
          busy[i] <= 1'b0;
        end
      end
      dbg_q <= (ZERO_REG && bus.dbg_addr == '0) ? '0 : mem[bus.dbg_addr];
    end
  end

  assign bus.dbg_data = dbg_q;

  // Flattened stored-state views (never forwarded).
  for (genvar i = 0; i < DEPTH; i++) begin : g_all
    if (ZERO_REG && i == 0) begin : g_zero
      assign bus.r_all[i*DATA_W +: DATA_W] = '0;
      assign bus.busy_all[i]               = 1'b0;
    end else begin : g_reg
      assign bus.r_all[i*DATA_W +: DATA_W] = mem[i];
      assign bus.busy_all[i]               = busy[i];
    end
  end

  // Two independent read ports.
  logic [1:0][DATA_W-1:0] rd_v;
  logic [1:0]             rb_v;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_l;
    logic              rb_l;

    assign ra = (p == 0) ? bus.ra1 : bus.ra2;

    // Stored value, overridden by a same-cycle write (B before A), then by the zero register.
    always_comb begin
      rd_l = mem[ra];
      rb_l = busy[ra];
      if (BYPASS && !rst) begin
        if (bus.we_b && bus.wa_b == ra) begin
          rd_l = bus.wd_b;
          rb_l = 1'b0;
        end else if (bus.we_a && bus.wa_a == ra) begin
          rd_l = bus.wd_a;
          rb_l = 1'b0;
        end
      end
      if (ZERO_REG && ra == '0) begin
        rd_l = '0;
        rb_l = 1'b0;
      end
    end

    assign rd_v[p] = rd_l;
    assign rb_v[p] = rb_l;
  end

  assign bus.rd1    = rd_v[0];
  assign bus.rd2    = rd_v[1];
  assign bus.rbusy1 = rb_v[0];
  assign bus.rbusy2 = rb_v[1];

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp. Two builds share one stimulus stream:
// dut (BYPASS=1, ZERO_REG=0) and dut_z (BYPASS=0, ZERO_REG=1).
module tb_register_file_mp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  register_file_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  register_file_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_z ();

  assign bus_z.ra1      = bus.ra1;
  assign bus_z.ra2      = bus.ra2;
  assign bus_z.we_a     = bus.we_a;
  assign bus_z.wa_a     = bus.wa_a;
  assign bus_z.wd_a     = bus.wd_a;
  assign bus_z.we_b     = bus.we_b;
  assign bus_z.wa_b     = bus.wa_b;
  assign bus_z.wd_b     = bus.wd_b;
  assign bus_z.set_en   = bus.set_en;
  assign bus_z.set_addr = bus.set_addr;
  assign bus_z.dbg_addr = bus.dbg_addr;

  register_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  register_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_z (
    .clk (clk),
    .rst (rst),
    .bus (bus_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we_a = 1'b0; bus.wa_a = '0; bus.wd_a = '0;
    bus.we_b = 1'b0; bus.wa_b = '0; bus.wd_b = '0;
    bus.set_en = 1'b0; bus.set_addr = '0;
  endtask

  task automatic test_reset();
    // populate some state
    idle();
    rst = 1'b0;
    bus.we_a = 1'b1; bus.wa_a = 3'd4; bus.wd_a = 32'h4444_0000;
    bus.we_b = 1'b1; bus.wa_b = 3'd1; bus.wd_b = 32'h1111_0000;
    bus.set_en = 1'b1; bus.set_addr = 3'd7;
    tick();
    idle();
    #1;
    checks++;
    if (bus.busy_all[7] !== 1'b1) begin
      failures++; $display("FAIL pre_reset_busy7 got=%b exp=1", bus.busy_all[7]);
    end
    // reset edge with a write presented: bypass suppressed, write dropped
    rst = 1'b1;
    bus.ra1 = 3'd4; bus.ra2 = 3'd1;
    bus.we_a = 1'b1; bus.wa_a = 3'd4; bus.wd_a = 32'hDEAD_BEEF;
    bus.set_en = 1'b1; bus.set_addr = 3'd5;
    #1;
    checks++;
    if (bus.rd1 !== 32'h4444_0000) begin
      failures++; $display("FAIL rst_no_bypass got=%h exp=%h", bus.rd1, 32'h4444_0000);
    end
    tick();
    rst = 1'b0;
    idle();
    #1;
    checks++;
    if (bus.r_all !== '0) begin
      failures++; $display("FAIL reset_r_all got=%h exp=0", bus.r_all);
    end
    checks++;
    if (bus.busy_all !== '0 || bus_z.busy_all !== '0) begin
      failures++; $display("FAIL reset_busy_all got=%b/%b exp=0", bus.busy_all, bus_z.busy_all);
    end
    checks++;
    if (bus.dbg_data !== '0) begin
      failures++; $display("FAIL reset_dbg got=%h exp=0", bus.dbg_data);
    end
    checks++;
    if (bus.rd1 !== '0 || bus.rd2 !== '0) begin
      failures++; $display("FAIL reset_rd got=%h/%h exp=0/0", bus.rd1, bus.rd2);
    end
  endtask

  task automatic test_bypass();
    idle();
    bus.ra1 = 3'd3;
    bus.we_a = 1'b1; bus.wa_a = 3'd3; bus.wd_a = 32'hAAAA_AAAA;
    #1;
    checks++;
    if (bus.rd1 !== 32'hAAAA_AAAA) begin
      failures++; $display("FAIL bypass_rd1 got=%h exp=%h", bus.rd1, 32'hAAAA_AAAA);
    end
    checks++;
    if (bus_z.rd1 !== 32'h0) begin
      failures++; $display("FAIL nobypass_rd1 got=%h exp=0", bus_z.rd1);
    end
    checks++;
    if (bus.r_all[3*DATA_W +: DATA_W] !== 32'h0) begin
      failures++; $display("FAIL r_all_not_bypassed got=%h exp=0", bus.r_all[3*DATA_W +: DATA_W]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.rd1 !== 32'hAAAA_AAAA || bus_z.rd1 !== 32'hAAAA_AAAA) begin
      failures++; $display("FAIL stored_rd1 got=%h/%h exp=%h", bus.rd1, bus_z.rd1, 32'hAAAA_AAAA);
    end
  endtask

  task automatic test_priority();
    idle();
    bus.ra2 = 3'd5;
    bus.we_a = 1'b1; bus.wa_a = 3'd5; bus.wd_a = 32'h1234_5678;
    bus.we_b = 1'b1; bus.wa_b = 3'd5; bus.wd_b = 32'h8765_4321;
    #1;
    checks++;
    if (bus.rd2 !== 32'h8765_4321) begin
      failures++; $display("FAIL prio_bypass_rd2 got=%h exp=%h", bus.rd2, 32'h8765_4321);
    end
    checks++;
    if (bus_z.rd2 !== 32'h0) begin
      failures++; $display("FAIL prio_nobypass_rd2 got=%h exp=0", bus_z.rd2);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.r_all[5*DATA_W +: DATA_W] !== 32'h8765_4321 ||
        bus_z.r_all[5*DATA_W +: DATA_W] !== 32'h8765_4321) begin
      failures++; $display("FAIL prio_stored got=%h/%h exp=%h", bus.r_all[5*DATA_W +: DATA_W],
                           bus_z.r_all[5*DATA_W +: DATA_W], 32'h8765_4321);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    bus.ra1 = 3'd6;
    bus.set_en = 1'b1; bus.set_addr = 3'd6;
    #1;
    checks++;
    if (bus.rbusy1 !== 1'b0) begin
      failures++; $display("FAIL set_not_comb got=%b exp=0", bus.rbusy1);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.busy_all[6] !== 1'b1 || bus.rbusy1 !== 1'b1) begin
      failures++; $display("FAIL busy_set got=%b/%b exp=1/1", bus.busy_all[6], bus.rbusy1);
    end
    bus.we_b = 1'b1; bus.wa_b = 3'd6; bus.wd_b = 32'h1111_1111;
    #1;
    checks++;
    if (bus.rbusy1 !== 1'b0) begin
      failures++; $display("FAIL busy_forwarded got=%b exp=0", bus.rbusy1);
    end
    checks++;
    if (bus_z.rbusy1 !== 1'b1) begin
      failures++; $display("FAIL busy_nobypass got=%b exp=1", bus_z.rbusy1);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.busy_all[6] !== 1'b0 || bus.rd1 !== 32'h1111_1111) begin
      failures++; $display("FAIL busy_cleared got=%b rd=%h exp=0 %h", bus.busy_all[6], bus.rd1, 32'h1111_1111);
    end
  endtask

  task automatic test_set_write_same();
    idle();
    bus.ra2 = 3'd2;
    bus.set_en = 1'b1; bus.set_addr = 3'd2;
    bus.we_a = 1'b1; bus.wa_a = 3'd2; bus.wd_a = 32'h2222_2222;
    tick();
    idle();
    #1;
    checks++;
    if (bus.busy_all[2] !== 1'b1 || bus.rbusy2 !== 1'b1) begin
      failures++; $display("FAIL set_wins got=%b/%b exp=1/1", bus.busy_all[2], bus.rbusy2);
    end
    checks++;
    if (bus.r_all[2*DATA_W +: DATA_W] !== 32'h2222_2222) begin
      failures++; $display("FAIL set_write_data got=%h exp=%h", bus.r_all[2*DATA_W +: DATA_W], 32'h2222_2222);
    end
  endtask

  task automatic test_zero();
    idle();
    bus.ra1 = 3'd0; bus.dbg_addr = 3'd0;
    bus.we_a = 1'b1; bus.wa_a = 3'd0; bus.wd_a = 32'hFFFF_FFFF;
    bus.set_en = 1'b1; bus.set_addr = 3'd0;
    #1;
    checks++;
    if (bus_z.rd1 !== 32'h0 || bus_z.rbusy1 !== 1'b0) begin
      failures++; $display("FAIL zero_rd_comb got=%h/%b exp=0/0", bus_z.rd1, bus_z.rbusy1);
    end
    checks++;
    if (bus.rd1 !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL reg0_bypass got=%h exp=%h", bus.rd1, 32'hFFFF_FFFF);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus_z.busy_all[0] !== 1'b0 || bus_z.rd1 !== 32'h0 || bus_z.r_all[0 +: DATA_W] !== 32'h0) begin
      failures++; $display("FAIL zero_after got=%b/%h/%h exp=0/0/0", bus_z.busy_all[0], bus_z.rd1,
                           bus_z.r_all[0 +: DATA_W]);
    end
    checks++;
    if (bus.busy_all[0] !== 1'b1 || bus.rd1 !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL reg0_normal got=%b/%h exp=1/%h", bus.busy_all[0], bus.rd1, 32'hFFFF_FFFF);
    end
    checks++;
    if (bus.dbg_data !== 32'h0) begin
      failures++; $display("FAIL dbg_prewrite got=%h exp=0", bus.dbg_data);
    end
    tick();
    #1;
    checks++;
    if (bus_z.dbg_data !== 32'h0 || bus.dbg_data !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL dbg_latency got=%h/%h exp=0/%h", bus_z.dbg_data, bus.dbg_data, 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    bus.we_a = 1'b1; bus.wa_a = 3'd1; bus.wd_a = 32'h0101_0101;
    bus.we_b = 1'b1; bus.wa_b = 3'd7; bus.wd_b = 32'h0707_0707;
    tick();
    bus.wa_a = 3'd1; bus.wd_a = 32'hCAFE_0001;
    bus.wa_b = 3'd4; bus.wd_b = 32'hCAFE_0004;
    bus.ra1 = 3'd1; bus.ra2 = 3'd7; bus.dbg_addr = 3'd7;
    #1;
    checks++;
    if (bus.rd1 !== 32'hCAFE_0001 || bus.rd2 !== 32'h0707_0707) begin
      failures++; $display("FAIL b2b_bypass got=%h/%h exp=%h/%h", bus.rd1, bus.rd2, 32'hCAFE_0001, 32'h0707_0707);
    end
    checks++;
    if (bus_z.rd1 !== 32'h0101_0101) begin
      failures++; $display("FAIL b2b_stored got=%h exp=%h", bus_z.rd1, 32'h0101_0101);
    end
    tick();
    idle();
    bus.ra2 = 3'd4;
    #1;
    checks++;
    if (bus.rd1 !== 32'hCAFE_0001 || bus.rd2 !== 32'hCAFE_0004 || bus.dbg_data !== 32'h0707_0707) begin
      failures++; $display("FAIL b2b_final got=%h/%h dbg=%h exp=%h/%h dbg=%h", bus.rd1, bus.rd2, bus.dbg_data,
                           32'hCAFE_0001, 32'hCAFE_0004, 32'h0707_0707);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.ra1 = '0; bus.ra2 = '0; bus.dbg_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_bypass();
    test_priority();
    test_scoreboard();
    test_set_write_same();
    test_zero();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
